// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU and the
// sequencers that borrow it.
//   - ALU control codes (3-bit) understood by the shared ALU
//   - seq_state_t: 2-bit binary state encoding used by mul_seq_ctrl
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_SLL = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle unsigned 32x32 multiply sequencer (MULTU).
// Runs a shift-add loop of WIDTH iterations, borrowing the shared ALU
// adder for one add per iteration, and leaves the 64-bit product in hi/lo.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, sampled only while idle
//   multiplicand        operand A, captured when start is accepted
//   multiplier          operand B, captured when start is accepted
//   busy                high while iterating and in the done cycle
//   done                one-cycle pulse; hi/lo valid from this cycle on
//   hi, lo              product[63:32] / product[31:0], held until next result
//   alu_sel             1 = this block owns the ALU inputs (iterating only)
//   alu_a, alu_b        ALU operands
//   alu_ctrl, alu_shamt ALU control code, shift amount (always 0)
//   alu_result          ALU output, combinational in the same cycle
module mul_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   output logic [4:0]       alu_shamt,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int CW = $clog2(WIDTH);

   // The ALU has no carry-out, so rebuild it from the operand and sum MSBs:
   // a carry occurred if both MSBs were set, or one was set and the sum MSB
   // came out clear.
   function automatic logic carry_f(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] sum);
      carry_f = (a[WIDTH-1] & b[WIDTH-1]) |
                ((a[WIDTH-1] | b[WIDTH-1]) & ~sum[WIDTH-1]);
   endfunction

   seq_state_t       state_r, state_s;
   logic [WIDTH-1:0] acc_hi_r, acc_hi_s;
   logic [WIDTH-1:0] acc_lo_r, acc_lo_s;
   logic [WIDTH-1:0] mcand_r, mcand_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [WIDTH-1:0] hi_r, hi_s;
   logic [WIDTH-1:0] lo_r, lo_s;
   logic             busy_r, done_r, alu_sel_r;
   logic             add_s;
   logic             zero_s;
   logic             carry_s;

   // An add is needed only while iterating and the current multiplier bit is set.
   always_comb begin
      add_s = (state_r == S_ITER) && acc_lo_r[0];
      if (add_s) begin
         alu_a    = acc_hi_r;
         alu_b    = mcand_r;
         alu_ctrl = ALU_ADD;
      end else begin
         alu_a    = {WIDTH{1'b0}};
         alu_b    = {WIDTH{1'b0}};
         alu_ctrl = ALU_AND;
      end
      alu_shamt = 5'd0;
      carry_s   = carry_f(acc_hi_r, mcand_r, alu_result);
      zero_s    = ZERO_SKIP && ((multiplicand == {WIDTH{1'b0}}) ||
                                (multiplier   == {WIDTH{1'b0}}));
   end

   // Next-state, accumulator and result-register logic.
   always_comb begin
      state_s  = state_r;
      acc_hi_s = acc_hi_r;
      acc_lo_s = acc_lo_r;
      mcand_s  = mcand_r;
      cnt_s    = cnt_r;
      hi_s     = hi_r;
      lo_s     = lo_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               mcand_s  = multiplicand;
               acc_hi_s = {WIDTH{1'b0}};
               acc_lo_s = multiplier;
               cnt_s    = {CW{1'b0}};
               if (zero_s) begin
                  // Product is known to be zero: publish it immediately.
                  state_s = S_DONE;
                  hi_s    = {WIDTH{1'b0}};
                  lo_s    = {WIDTH{1'b0}};
               end else begin
                  state_s = S_ITER;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ITER: begin
            // 65-bit {carry, sum, acc_lo} shifted right by one, low 64 bits kept.
            if (acc_lo_r[0]) begin
               acc_hi_s = {carry_s, alu_result[WIDTH-1:1]};
               acc_lo_s = {alu_result[0], acc_lo_r[WIDTH-1:1]};
            end else begin
               acc_hi_s = {1'b0, acc_hi_r[WIDTH-1:1]};
               acc_lo_s = {acc_hi_r[0], acc_lo_r[WIDTH-1:1]};
            end
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(WIDTH - 1)) begin
               // Final iteration: hi/lo take the finished product directly.
               state_s = S_DONE;
               hi_s    = acc_hi_s;
               lo_s    = acc_lo_s;
            end else begin
               state_s = S_ITER;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         acc_hi_r  <= {WIDTH{1'b0}};
         acc_lo_r  <= {WIDTH{1'b0}};
         mcand_r   <= {WIDTH{1'b0}};
         cnt_r     <= {CW{1'b0}};
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         alu_sel_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         acc_hi_r  <= acc_hi_s;
         acc_lo_r  <= acc_lo_s;
         mcand_r   <= mcand_s;
         cnt_r     <= cnt_s;
         hi_r      <= hi_s;
         lo_r      <= lo_s;
         busy_r    <= (state_s != S_IDLE);
         done_r    <= (state_s == S_DONE);
         alu_sel_r <= (state_s == S_ITER);
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign alu_sel = alu_sel_r;
   assign hi      = hi_r;
   assign lo      = lo_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: self-checking bench for mul_seq_ctrl. Two instances
// (ZERO_SKIP=1 and ZERO_SKIP=0) each get their own behavioural ALU; the
// reference product is plain 64-bit multiplication.
module tb_mul_seq_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] mcand, mplier;
   int          sel;      // 0 = ZERO_SKIP=1 instance, 1 = ZERO_SKIP=0 instance

   logic        start1, busy1, done1, alu_sel1;
   logic [31:0] hi1, lo1, alu_a1, alu_b1, alu_res1;
   logic [2:0]  alu_ctrl1;
   logic [4:0]  alu_shamt1;
   logic        start0, busy0, done0, alu_sel0;
   logic [31:0] hi0, lo0, alu_a0, alu_b0, alu_res0;
   logic [2:0]  alu_ctrl0;
   logic [4:0]  alu_shamt0;

   int checks = 0;
   int errors = 0;
   logic [63:0] prev [2];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [2:0] c);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         default: return 32'd0;
      endcase
   endfunction

   assign start1   = (sel == 0) ? start : 1'b0;
   assign start0   = (sel == 1) ? start : 1'b0;
   assign alu_res1 = alu_f(alu_a1, alu_b1, alu_ctrl1);
   assign alu_res0 = alu_f(alu_a0, alu_b0, alu_ctrl0);

   mul_seq_ctrl #(.WIDTH(32), .ZERO_SKIP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .multiplicand(mcand), .multiplier(mplier),
      .busy(busy1), .done(done1), .hi(hi1), .lo(lo1),
      .alu_sel(alu_sel1), .alu_a(alu_a1), .alu_b(alu_b1),
      .alu_ctrl(alu_ctrl1), .alu_shamt(alu_shamt1), .alu_result(alu_res1));

   mul_seq_ctrl #(.WIDTH(32), .ZERO_SKIP(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .multiplicand(mcand), .multiplier(mplier),
      .busy(busy0), .done(done0), .hi(hi0), .lo(lo0),
      .alu_sel(alu_sel0), .alu_a(alu_a0), .alu_b(alu_b0),
      .alu_ctrl(alu_ctrl0), .alu_shamt(alu_shamt0), .alu_result(alu_res0));

   // Observation view of the currently selected instance.
   logic        o_busy, o_done, o_alu_sel;
   logic [63:0] o_prod;
   logic [31:0] o_a, o_b;
   logic [2:0]  o_ctrl;
   logic [4:0]  o_shamt;
   assign o_busy    = sel ? busy0 : busy1;
   assign o_done    = sel ? done0 : done1;
   assign o_alu_sel = sel ? alu_sel0 : alu_sel1;
   assign o_prod    = sel ? {hi0, lo0} : {hi1, lo1};
   assign o_a       = sel ? alu_a0 : alu_a1;
   assign o_b       = sel ? alu_b0 : alu_b1;
   assign o_ctrl    = sel ? alu_ctrl0 : alu_ctrl1;
   assign o_shamt   = sel ? alu_shamt0 : alu_shamt1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One multiply: start at E0, follow the run cycle by cycle, check the result.
   task automatic do_job(input logic [31:0] a, input logic [31:0] b, input bit hold);
      logic [63:0] exp;
      int exp_lat, k, ctrl_bad, hold_bad, busy_cnt;
      exp     = 64'(a) * 64'(b);
      exp_lat = (sel == 0 && (a == 32'd0 || b == 32'd0)) ? 0 : 32;
      @(negedge clk);
      start = 1'b1; mcand = a; mplier = b;
      @(posedge clk); #1;
      k = 0; ctrl_bad = 0; hold_bad = 0; busy_cnt = 0;
      while (!o_done && k < 40) begin
         if (!hold) start = 1'b0;
         mcand = $urandom; mplier = $urandom;
         if (o_busy) busy_cnt++;
         if (k < 32) begin
            if (o_alu_sel !== 1'b1) ctrl_bad++;
            if (b[k]) begin
               if (o_ctrl !== ALU_ADD || o_b !== a) ctrl_bad++;
            end else begin
               if (o_ctrl !== ALU_AND || o_a !== 32'd0 || o_b !== 32'd0) ctrl_bad++;
            end
         end
         if (o_prod !== prev[sel]) hold_bad++;
         @(posedge clk); #1;
         k++;
      end
      if (o_busy) busy_cnt++;
      check("latency",    64'(k), 64'(exp_lat));
      check("product",    o_prod, exp);
      check("busy_cycles", 64'(busy_cnt), 64'(exp_lat + 1));
      check("alu_ctrl_seq", 64'(ctrl_bad), 64'd0);
      check("hilo_hold",  64'(hold_bad), 64'd0);
      check("alu_sel_done", 64'(o_alu_sel), 64'd0);
      check("alu_shamt",  64'(o_shamt), 64'd0);
      @(posedge clk); #1;
      check("done_pulse", {62'd0, o_done, o_busy}, 64'd0);
      check("product_held", o_prod, exp);
      start = 1'b0;
      prev[sel] = exp;
   endtask

   initial begin
      logic [31:0] ra, rb;
      start = 1'b0; mcand = 32'd0; mplier = 32'd0; sel = 0; rst_n = 1'b0;
      prev[0] = 64'd0; prev[1] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", {60'd0, busy1, done1, alu_sel1, busy0}, 64'd0);
      check("reset_prod", {hi1, lo1}, 64'd0);
      check("reset_alu", {27'd0, alu_ctrl1, alu_a1}, 64'd0);
      @(negedge clk) rst_n = 1'b1;

      do_job(32'd3, 32'd5, 1'b0);
      do_job(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      do_job(32'h80000000, 32'h00000002, 1'b0);
      do_job(32'd0, 32'h1234, 1'b0);
      sel = 1;
      do_job(32'd0, 32'h1234, 1'b0);
      do_job(32'hDEADBEEF, 32'h00000000, 1'b0);
      sel = 0;
      do_job(32'd9, 32'd11, 1'b1);
      do_job(32'h12345678, 32'h9ABCDEF0, 1'b1);

      // Reset in the middle of iteration 10.
      @(negedge clk);
      start = 1'b1; mcand = 32'h1234; mplier = 32'h5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out", {61'd0, busy1, done1, alu_sel1}, 64'd0);
      check("abort_prod", {hi1, lo1}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      prev[0] = 64'd0;
      begin
         int dcnt;
         dcnt = 0;
         repeat (36) begin
            @(posedge clk); #1;
            if (done1 || busy1) dcnt++;
         end
         check("no_done_after_abort", 64'(dcnt), 64'd0);
      end
      do_job(32'd7, 32'd6, 1'b0);

      for (int i = 0; i < 16; i++) begin
         ra = $urandom; rb = $urandom;
         if (i % 5 == 3) ra = 32'd0;
         if (i % 7 == 4) rb = 32'd0;
         sel = (i % 4 == 1) ? 1 : 0;
         do_job(ra, rb, (i % 3 == 0) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
